// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg: shared FSM state type and Wishbone bus widths.
package wb_cmd_master_pkg;
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
   localparam int WB_ADDR_W = 32;
   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: cycle counter with clear/enable; tc_o flags count == LIMIT-1.
module wb_timeout_ctr #(
   parameter int W     = 8,
   parameter int LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) cnt_q <= '0;
      else if (en_i)      cnt_q <= cnt_q + 1'b1;
   end
   assign tc_o = cnt_q == TC_VAL;
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command stream to Wishbone classic single
// read/write cycles, one response per command, with a bus timeout.
module wb_cmd_master
   import wb_cmd_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic                 wb_clock_i,
   input  logic                 wb_reset_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_i,
   input  logic [WB_ADDR_W-1:0] cmd_addr_i,
   input  logic [WB_DATA_W-1:0] cmd_data_i,
   input  logic [WB_SEL_W-1:0]  cmd_sel_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [WB_DATA_W-1:0] rsp_data_o,
   output logic                 rsp_timeout_o,
   output logic                 wb_cyc_o,
   output logic                 wb_strobe_o,
   output logic                 wb_we_o,
   output logic [WB_ADDR_W-1:0] wb_addr_o,
   output logic [WB_DATA_W-1:0] wb_data_o,
   output logic [WB_SEL_W-1:0]  wb_sel_o,
   input  logic [WB_DATA_W-1:0] wb_data_i,
   input  logic                 wb_ack_i
);
   state_e               state_q;
   logic                 cmd_ready_q, cyc_q, we_q, rsp_valid_q, rsp_timeout_q;
   logic [WB_ADDR_W-1:0] addr_q;
   logic [WB_DATA_W-1:0] data_q, rsp_data_q;
   logic [WB_SEL_W-1:0]  sel_q;
   logic                 accept, tc;
   // cmd_ready_q is only ever high in IDLE, so it alone qualifies acceptance
   assign accept = cmd_ready_q & cmd_valid_i;
   wb_timeout_ctr #(.W(TIMEOUT_W), .LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk_i (wb_clock_i),
      .rst_i (wb_reset_i),
      .clr_i (accept),
      .en_i  (state_q == BUS && !wb_ack_i),
      .tc_o  (tc)
   );
   always_ff @(posedge wb_clock_i) begin
      if (wb_reset_i) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         cyc_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         sel_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cmd_ready_q <= 1'b0;
                  cyc_q       <= 1'b1;
                  we_q        <= cmd_we_i;
                  addr_q      <= cmd_addr_i;
                  data_q      <= cmd_data_i;
                  sel_q       <= cmd_sel_i;
                  state_q     <= BUS;
               end else cmd_ready_q <= 1'b1;
            end
            BUS: begin
               // ack beats a simultaneous terminal count
               if (wb_ack_i || tc) begin
                  cyc_q         <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_data_q    <= (wb_ack_i && !we_q) ? wb_data_i : '0;
                  rsp_timeout_q <= !wb_ack_i;
                  state_q       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q   <= 1'b0;
                  rsp_data_q    <= '0;
                  rsp_timeout_q <= 1'b0;
                  cmd_ready_q   <= 1'b1;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign cmd_ready_o   = cmd_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_data_o    = rsp_data_q;
   assign rsp_timeout_o = rsp_timeout_q;
   assign wb_cyc_o      = cyc_q;
   assign wb_strobe_o   = cyc_q;
   assign wb_we_o       = we_q;
   assign wb_addr_o     = addr_q;
   assign wb_data_o     = data_q;
   assign wb_sel_o      = sel_q;
endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic-cycle initiator that turns a simple valid/ready command stream into single Wishbone read or write transactions and returns one response per command. It is the bus-master counterpart of the `top_4ft4` Wishbone responder port (`wb_*_i` in, `wb_data_o`/`wb_ack_o` out). It lets on-chip bring-up logic drive that responder directly, for example through an LA-pin sequencer. A per-transaction timeout guarantees forward progress when the responder never acks.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles `wb_cyc_o` may stay high without `wb_ack_i` before the transaction is abandoned. Range 1..2^TIMEOUT_W-1.
- `TIMEOUT_W`, 8: width of the timeout counter.

Ports:
- `wb_clock_i` in 1: sole clock; all logic is rising-edge.
- `wb_reset_i` in 1: reset, synchronous and active-high.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: command accepted when high together with `cmd_valid_i`.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in 32: byte address.
- `cmd_data_i` in 32: write data.
- `cmd_sel_i` in 4: byte lanes.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed when high together with `rsp_valid_o`.
- `rsp_data_o` out 32: read data. Always 0 for writes and for timeouts.
- `rsp_timeout_o` out 1: transaction abandoned with no ack.
- `wb_cyc_o`, `wb_strobe_o`, `wb_we_o` out 1 each: Wishbone master controls.
- `wb_addr_o` out 32, `wb_data_o` out 32, `wb_sel_o` out 4: Wishbone master address, write data and byte selects.
- `wb_data_i` in 32: Wishbone read data.
- `wb_ack_i` in 1: Wishbone acknowledge.

## Operation
- FSM states: IDLE, BUS, RESP. Reset forces IDLE.
- IDLE:
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`, latch we/addr/data/sel into the output registers, clear the timeout counter, go to BUS.
- BUS:
  - `wb_cyc_o`=`wb_strobe_o`=1; we/addr/data/sel held stable; `cmd_ready_o`=0.
  - Timeout counter increments each BUS cycle without ack.
  - On `wb_ack_i`: capture `wb_data_i` into `rsp_data_o` if read, otherwise load 0; `rsp_timeout_o`=0; go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES - 1` with no ack that cycle: `rsp_data_o`=0, `rsp_timeout_o`=1, go to RESP.
- RESP:
  - `rsp_valid_o`=1, cyc/stb=0.
  - On `rsp_ready_i`, go to IDLE.
  - `rsp_data_o` and `rsp_timeout_o` stay stable while `rsp_valid_o`=1.
- `wb_ack_i` is ignored outside BUS; no state or output changes.
- Ack and timeout in the same cycle: ack wins, giving a normal response.
- Only one outstanding transaction. No pipelined mode, no burst, no err/rty.
- Reset mid-transaction: cyc/stb drop at the next edge, the response is discarded and the FSM returns to IDLE. No response is ever issued for the aborted command.
- Reset values: `cmd_ready_o`=0 while `wb_reset_i`=1, then 1 in IDLE. All other outputs are 0.

## Timing
- Command accepted at edge N; `wb_cyc_o`/`wb_strobe_o` high from edge N to edge N+1.
- Ack sampled at edge N+k (k≥1); cyc/stb low and `rsp_valid_o` high after edge N+k.
- Best case, with ack in the first bus cycle: accept → `rsp_valid_o` in 2 cycles; next command accepted 1 cycle after the response handshake. Peak throughput is 1 transaction per 3 cycles.
- Timeout: cyc/stb high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid_o` rises on the next cycle.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package `wb_cmd_master_pkg`:
  - state enum (IDLE/BUS/RESP);
  - constants `WB_ADDR_W`=32, `WB_DATA_W`=32, `WB_SEL_W`=4.
- Sub-module `wb_timeout_ctr`: parameterised counter with clear, enable and terminal-count output; `TIMEOUT_W`-bit, sync active-high reset.
- Top holds the FSM, the command/output registers and the response register.

## Test plan
- Write, immediate ack: cmd we=1 addr=0x3000_0004 data=0xDEAD_BEEF sel=0xF.
  - Required: one cycle of cyc/stb/we=1 carrying those values.
  - Required: `rsp_valid_o` 2 cycles after accept with data=0, timeout=0.
- Read, ack after 3 cycles with `wb_data_i`=0x1234_5678.
  - Required: cyc/stb high 3 cycles, we=0.
  - Required: rsp_data=0x1234_5678, timeout=0.
- Timeout: `TIMEOUT_CYCLES`=4, never ack.
  - Required: cyc/stb high exactly 4 cycles.
  - Required: rsp timeout=1, data=0, `wb_cyc_o`=0 after.
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles.
  - Required: `rsp_valid_o`/`rsp_data_o` stable and `cmd_ready_o`=0 throughout.
  - Required: next command accepted 1 cycle after release.
- Corner events:
  - ack exactly on the timeout cycle → timeout=0 and data captured;
  - stray ack in IDLE → no output change.
- Reset asserted mid-BUS:
  - cyc/stb=0 and `rsp_valid_o`=0 after the next edge;
  - after reset release, `cmd_ready_o`=1 and no response is ever produced.
